instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Consumer side of the PC register interface.
- Reads the current PC value, checks that it is word-aligned and inside the instruction ROM window at 0x400000, and issues a word read to the instruction memory over a req/ready, rvalid handshake.
- Holds the returned instruction for the decode stage under a valid/ready handshake, then pulses pc_advance so the PC register may load its next value.

Parameters:
- N, 32, data/address width of the PC and instruction.
- ROM_BASE, 'h400000, byte address of ROM word 0.
- ADDR_W, 8, ROM word-address width; the ROM holds 2^ADDR_W words.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_value  input  N  current PC from the PC register.
- fetch_en  input  1  permits a new fetch to start.
- mem_req  output  1  read request to instruction memory.
- mem_addr  output  ADDR_W  ROM word address, equal to (pc - ROM_BASE) >> 2.
- mem_ready  input  1  memory accepts the request this cycle.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  N  read data.
- instr_valid  output  1  instr and instr_pc are valid.
- instr  output  N  fetched instruction.
- instr_pc  output  N  PC of the fetched instruction.
- instr_ready  input  1  decode accepts the instruction.
- pc_advance  output  1  one-cycle pulse that allows the PC register to update.
- fault  output  1  sticky alignment or range fault.

Behaviour:
- Reset, asynchronous: state=IDLE. All outputs are 0: mem_req, mem_addr, instr_valid, instr, instr_pc, pc_advance, fault.
- States: IDLE, REQ, WAIT, HOLD, FAULT. All outputs are registered.
- IDLE:
  - Acts only when fetch_en=1 and pc_advance=0. This guard ensures the PC is never sampled in the same cycle it is being updated.
  - A PC is legal when pc_value[1:0]==0 and ROM_BASE <= pc_value <= ROM_BASE + 4*(2^ADDR_W) - 4. Comparisons are unsigned and N bits wide.
  - Legal PC: latch instr_pc=pc_value and mem_addr=(pc_value-ROM_BASE)>>2 truncated to ADDR_W bits; set mem_req=1; go to REQ.
  - Illegal PC: set fault=1; go to FAULT; never assert mem_req.
- REQ:
  - mem_req=1, with mem_addr and instr_pc held stable, until mem_ready=1 is sampled.
  - On acceptance: mem_req=0 next cycle, go to WAIT.
  - If mem_rvalid=1 in the same cycle as acceptance, capture instr=mem_rdata, set instr_valid=1, and go directly to HOLD.
- WAIT: on mem_rvalid=1, capture instr=mem_rdata, set instr_valid=1, go to HOLD. Memory latency is unbounded; no timeout.
- HOLD:
  - instr_valid=1; instr and instr_pc stay stable until instr_ready=1 is sampled.
  - Then instr_valid=0, pc_advance=1 for exactly the next cycle, go to IDLE.
- FAULT: sticky until reset. mem_req=0, instr_valid=0, pc_advance=0; all inputs are ignored.
- mem_rvalid outside WAIT, and outside the REQ acceptance cycle, is ignored and leaves instr unchanged.
- fetch_en=0 only blocks starting a new fetch from IDLE. A fetch in flight runs to the end of HOLD.
- pc_value changes during REQ, WAIT or HOLD have no effect, because the address was latched in IDLE.
- Latency, with mem_ready=1 immediately and rvalid one cycle after acceptance:
  - cycle 0: IDLE samples the PC.
  - cycle 1: mem_req high.
  - cycle 2: rvalid arrives.
  - cycle 3: instr_valid high.
  - If instr_ready=1 in cycle 3, pc_advance is high in cycle 4 and the next fetch can be sampled in cycle 5. Steady-state period is 5 cycles per instruction.
- Reset asserted in any state returns immediately to the reset values. A response arriving late after reset is ignored in IDLE.

Test Plan:
- Nominal fetch: reset, then pc_value=0x400000, fetch_en=1, mem_ready=1, mem_rvalid=1 one cycle after acceptance with mem_rdata=0x2010000A, instr_ready=1 -> mem_addr=0; instr_valid in cycle 3 with instr=0x2010000A and instr_pc=0x400000; pc_advance high for exactly one cycle (cycle 4).
- Request backpressure: pc_value=0x400008, mem_ready low for 3 cycles -> mem_req held high for 4 cycles with mem_addr=2 stable; pc_value changed to 0x400010 mid-REQ still reads address 2 and returns instr_pc=0x400008.
- Decode backpressure: instr_ready low for 4 cycles in HOLD -> instr_valid and instr held constant; pc_advance stays 0 until the cycle after instr_ready=1; a stray mem_rvalid with 0xFFFFFFFF during HOLD leaves instr unchanged.
- Faults:
  - pc_value=0x400002 -> fault=1 the next cycle; mem_req never asserts.
  - After reset, pc_value=0x400400 (one word past the end with ADDR_W=8) -> fault=1.
  - After reset, pc_value=0x3FFFFC -> fault=1.
  - pc_value=0x4003FC -> legal, mem_addr=255.
- Zero-latency memory: mem_ready=1 and mem_rvalid=1 in the same cycle with 0x8C080000 -> state moves REQ to HOLD; instr_valid the next cycle with instr=0x8C080000.
- Reset mid-operation: assert reset while in WAIT -> all outputs 0 immediately; after release with fetch_en=0, a mem_rvalid pulse causes no instr_valid and no pc_advance.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC consumer that fetches one ROM word per PC and hands it to decode
module instr_fetch_unit #(
  parameter int             N        = 32,
  parameter logic [N-1:0]   ROM_BASE = N'('h400000),
  parameter int             ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      pc_value,
  input  logic              fetch_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [N-1:0]      mem_rdata,
  output logic              instr_valid,
  output logic [N-1:0]      instr,
  output logic [N-1:0]      instr_pc,
  input  logic              instr_ready,
  output logic              pc_advance,
  output logic              fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  // Byte address of the last word inside the ROM window.
  localparam logic [N-1:0] ROM_LAST = ROM_BASE + N'((1 << (ADDR_W + 2)) - 4);

  state_t              state, state_nxt;
  logic                mem_req_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic                instr_valid_nxt;
  logic [N-1:0]        instr_nxt;
  logic [N-1:0]        instr_pc_nxt;
  logic                pc_advance_nxt;
  logic                fault_nxt;

  logic                pc_legal;
  logic [ADDR_W-1:0]   pc_word;

  assign pc_legal = (pc_value[1:0] == 2'b00) && (pc_value >= ROM_BASE) && (pc_value <= ROM_LAST);
  assign pc_word  = ADDR_W'((pc_value - ROM_BASE) >> 2);

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      pc_advance  <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      mem_req     <= mem_req_nxt;
      mem_addr    <= mem_addr_nxt;
      instr_valid <= instr_valid_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      pc_advance  <= pc_advance_nxt;
      fault       <= fault_nxt;
    end
  end

  // Next-state and next-output decode; outputs hold unless a transition changes them.
  always_comb begin
    state_nxt       = state;
    mem_req_nxt     = mem_req;
    mem_addr_nxt    = mem_addr;
    instr_valid_nxt = instr_valid;
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    pc_advance_nxt  = 1'b0;
    fault_nxt       = fault;

    case (state)
      IDLE: begin
        // Skip the cycle where pc_advance is high so the PC is never read mid-update.
        if (fetch_en && !pc_advance) begin
          if (pc_legal) begin
            instr_pc_nxt = pc_value;
            mem_addr_nxt = pc_word;
            mem_req_nxt  = 1'b1;
            state_nxt    = REQ;
          end else begin
            fault_nxt = 1'b1;
            state_nxt = FAULT;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          mem_req_nxt = 1'b0;
          if (mem_rvalid) begin
            instr_nxt       = mem_rdata;
            instr_valid_nxt = 1'b1;
            state_nxt       = HOLD;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          instr_nxt       = mem_rdata;
          instr_valid_nxt = 1'b1;
          state_nxt       = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          instr_valid_nxt = 1'b0;
          pc_advance_nxt  = 1'b1;
          state_nxt       = IDLE;
        end
      end
      FAULT: begin
        mem_req_nxt     = 1'b0;
        instr_valid_nxt = 1'b0;
        fault_nxt       = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pc_value;
  logic        fetch_en;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        pc_advance;
  logic        fault;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .pc_value    (pc_value),
    .fetch_en    (fetch_en),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .pc_advance  (pc_advance),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    pc_value    = '0;
    fetch_en    = 1'b0;
    mem_ready   = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    instr_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [75:0] obs;
    do_reset();
    reset    = 1'b1;
    pc_value = 32'h400000;
    fetch_en = 1'b1;
    step();
    obs = {mem_req, mem_addr, instr_valid, instr, instr_pc, pc_advance, fault};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", obs);
    end
    step();
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_holds_idle mem_req got=%b exp=0", mem_req);
    end
    reset = 1'b0;
  endtask

  task automatic test_nominal();
    do_reset();
    pc_value    = 32'h400000;
    fetch_en    = 1'b1;
    mem_ready   = 1'b1;
    instr_ready = 1'b1;
    step();  // cycle 1
    fetch_en = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'd0) begin
      errors++;
      $display("FAIL nominal_req mem_req=%b mem_addr=%0d exp 1/0", mem_req, mem_addr);
    end
    step();  // cycle 2
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL nominal_wait mem_req=%b instr_valid=%b exp 0/0", mem_req, instr_valid);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h2010000A;
    sb.push_back('{32'h2010000A, 32'h400000});
    step();  // cycle 3
    mem_rvalid = 1'b0;
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL nominal_valid_cycle3 got=%b exp=1", instr_valid);
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (instr !== e.instr || instr_pc !== e.pc) begin
        errors++;
        $display("FAIL nominal_data instr=%h pc=%h exp %h/%h", instr, instr_pc, e.instr, e.pc);
      end
    end
    step();  // cycle 4
    checks++;
    if (pc_advance !== 1'b1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL nominal_advance pc_advance=%b instr_valid=%b exp 1/0", pc_advance, instr_valid);
    end
    step();  // cycle 5
    checks++;
    if (pc_advance !== 1'b0) begin
      errors++;
      $display("FAIL nominal_advance_pulse got=%b exp=0", pc_advance);
    end
  endtask

  task automatic test_req_backpressure();
    do_reset();
    pc_value    = 32'h400008;
    fetch_en    = 1'b1;
    mem_ready   = 1'b0;
    instr_ready = 1'b1;
    step();  // cycle 1
    fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 8'd2) begin
        errors++;
        $display("FAIL req_hold[%0d] mem_req=%b mem_addr=%0d exp 1/2", i, mem_req, mem_addr);
      end
      if (i == 1) pc_value = 32'h400010;
      if (i == 3) mem_ready = 1'b1;
      step();
    end
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL req_release got=%b exp=0", mem_req);
    end
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA5A50001;
    sb.push_back('{32'hA5A50001, 32'h400008});
    step();
    mem_rvalid = 1'b0;
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL req_bp_valid got=%b exp=1", instr_valid);
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (instr !== e.instr || instr_pc !== e.pc) begin
        errors++;
        $display("FAIL req_bp_data instr=%h pc=%h exp %h/%h", instr, instr_pc, e.instr, e.pc);
      end
    end
    step();
  endtask

  task automatic test_decode_backpressure();
    do_reset();
    pc_value    = 32'h40000C;
    fetch_en    = 1'b1;
    mem_ready   = 1'b1;
    instr_ready = 1'b0;
    step();  // cycle 1
    fetch_en = 1'b0;
    step();  // cycle 2
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    sb.push_back('{32'h12345678, 32'h40000C});
    step();  // cycle 3
    mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h12345678 || instr_pc !== 32'h40000C || pc_advance !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] valid=%b instr=%h pc=%h adv=%b exp 1/12345678/0040000c/0",
                 i, instr_valid, instr, instr_pc, pc_advance);
      end
      if (i == 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFFFFFF;
      end else begin
        mem_rvalid = 1'b0;
      end
      step();
    end
    instr_ready = 1'b1;
    checks++;
    if (instr_valid !== 1'b1 || pc_advance !== 1'b0) begin
      errors++;
      $display("FAIL hold_release valid=%b adv=%b exp 1/0", instr_valid, pc_advance);
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (instr !== e.instr || instr_pc !== e.pc) begin
        errors++;
        $display("FAIL hold_data instr=%h pc=%h exp %h/%h", instr, instr_pc, e.instr, e.pc);
      end
    end
    step();
    checks++;
    if (pc_advance !== 1'b1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_advance adv=%b valid=%b exp 1/0", pc_advance, instr_valid);
    end
    instr_ready = 1'b0;
    step();
  endtask

  task automatic test_faults();
    logic [31:0] fpc [4];
    logic        fexp[4];
    fpc  = '{32'h400002, 32'h400400, 32'h3FFFFC, 32'h4003FC};
    fexp = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      pc_value  = fpc[k];
      fetch_en  = 1'b1;
      mem_ready = 1'b0;
      step();
      checks++;
      if (fault !== fexp[k] || mem_req !== !fexp[k]) begin
        errors++;
        $display("FAIL fault_pc_%h fault=%b mem_req=%b exp %b/%b", fpc[k], fault, mem_req, fexp[k], !fexp[k]);
      end
      if (!fexp[k]) begin
        checks++;
        if (mem_addr !== 8'd255) begin
          errors++;
          $display("FAIL last_word_addr got=%0d exp=255", mem_addr);
        end
      end else begin
        pc_value   = 32'h400000;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        instr_ready = 1'b1;
        step();
        step();
        checks++;
        if (fault !== 1'b1 || mem_req !== 1'b0 || instr_valid !== 1'b0 || pc_advance !== 1'b0) begin
          errors++;
          $display("FAIL fault_sticky_%h fault=%b req=%b valid=%b adv=%b exp 1/0/0/0",
                   fpc[k], fault, mem_req, instr_valid, pc_advance);
        end
        mem_rvalid = 1'b0;
      end
    end
  endtask

  task automatic test_zero_latency();
    do_reset();
    pc_value    = 32'h400004;
    fetch_en    = 1'b1;
    mem_ready   = 1'b1;
    instr_ready = 1'b1;
    step();  // cycle 1, REQ
    fetch_en   = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h8C080000;
    sb.push_back('{32'h8C080000, 32'h400004});
    step();  // cycle 2
    mem_rvalid = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL zero_lat_valid valid=%b req=%b exp 1/0", instr_valid, mem_req);
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (instr !== e.instr || instr_pc !== e.pc) begin
        errors++;
        $display("FAIL zero_lat_data instr=%h pc=%h exp %h/%h", instr, instr_pc, e.instr, e.pc);
      end
    end
    step();
    checks++;
    if (pc_advance !== 1'b1) begin
      errors++;
      $display("FAIL zero_lat_advance got=%b exp=1", pc_advance);
    end
  endtask

  task automatic test_reset_mid();
    logic [75:0] obs;
    do_reset();
    pc_value    = 32'h400010;
    fetch_en    = 1'b1;
    mem_ready   = 1'b1;
    instr_ready = 1'b1;
    step();  // REQ
    fetch_en = 1'b0;
    step();  // WAIT
    checks++;
    if (mem_req !== 1'b0 || instr_pc !== 32'h400010 || mem_addr !== 8'd4) begin
      errors++;
      $display("FAIL mid_wait req=%b pc=%h addr=%0d exp 0/00400010/4", mem_req, instr_pc, mem_addr);
    end
    #1;
    reset = 1'b1;
    #1;
    obs = {mem_req, mem_addr, instr_valid, instr, instr_pc, pc_advance, fault};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL mid_async_reset got=%h exp=0", obs);
    end
    step();
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    step();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (instr_valid !== 1'b0 || pc_advance !== 1'b0 || instr !== 32'h0) begin
        errors++;
        $display("FAIL late_rvalid[%0d] valid=%b adv=%b instr=%h exp 0/0/0", i, instr_valid, pc_advance, instr);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cur_pc;
    logic [31:0] data;
    logic        pend;
    int          done;
    int          last_cyc;
    do_reset();
    cur_pc      = 32'h400020;
    pc_value    = cur_pc;
    fetch_en    = 1'b1;
    mem_ready   = 1'b1;
    instr_ready = 1'b1;
    pend        = 1'b0;
    done        = 0;
    last_cyc    = -1;
    data        = '0;
    for (int cyc = 0; cyc < 60 && done < 3; cyc++) begin
      step();
      mem_rvalid = 1'b0;
      if (pend) begin
        data       = $urandom;
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        sb.push_back('{data, cur_pc});
        pend = 1'b0;
      end
      if (mem_req) begin
        checks++;
        if (mem_addr !== 8'((cur_pc - 32'h400000) >> 2)) begin
          errors++;
          $display("FAIL b2b_addr got=%0d exp=%0d", mem_addr, (cur_pc - 32'h400000) >> 2);
        end
        pend = 1'b1;
      end
      if (instr_valid) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++;
          if (instr !== e.instr || instr_pc !== e.pc) begin
            errors++;
            $display("FAIL b2b_data instr=%h pc=%h exp %h/%h", instr, instr_pc, e.instr, e.pc);
          end
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != 5) begin
            errors++;
            $display("FAIL b2b_period got=%0d exp=5", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        done++;
      end
      if (pc_advance) begin
        cur_pc   = cur_pc + 32'd4;
        pc_value = cur_pc;
      end
    end
    fetch_en   = 1'b0;
    mem_rvalid = 1'b0;
    checks++;
    if (done != 3) begin
      errors++;
      $display("FAIL b2b_timeout got=%0d exp=3 instructions", done);
    end
  endtask

  initial begin
    reset       = 1'b1;
    pc_value    = '0;
    fetch_en    = 1'b0;
    mem_ready   = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    instr_ready = 1'b0;
    test_reset();
    test_nominal();
    test_req_backpressure();
    test_decode_backpressure();
    test_faults();
    test_zero_latency();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
